// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch_unit_pkg : encodings shared by the fetch stage and the decoder     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package pc_fetch_unit_pkg;

    localparam logic [2:0] c_MPC_HOLD = 3'd0;
    localparam logic [2:0] c_MPC_INC  = 3'd1;
    localparam logic [2:0] c_MPC_LOAD = 3'd2;
    localparam logic [2:0] c_MPC_JCC  = 3'd3;

    localparam logic [2:0] c_MAB_SEL_PC   = 3'd0;
    localparam logic [2:0] c_MAB_SEL_SOUT = 3'd1;
    localparam logic [2:0] c_MAB_SEL_CALC = 3'd2;
    localparam logic [2:0] c_MAB_SEL_MDB  = 3'd3;

    localparam logic [2:0] c_JCC_JNE = 3'd0;
    localparam logic [2:0] c_JCC_JEQ = 3'd1;
    localparam logic [2:0] c_JCC_JNC = 3'd2;
    localparam logic [2:0] c_JCC_JC  = 3'd3;
    localparam logic [2:0] c_JCC_JN  = 3'd4;
    localparam logic [2:0] c_JCC_JGE = 3'd5;
    localparam logic [2:0] c_JCC_JL  = 3'd6;
    localparam logic [2:0] c_JCC_JMP = 3'd7;

    localparam logic [15:0] c_RESET_VEC_ADDR = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_VEC   = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_t;

    // Instruction addresses are word aligned; bit 0 is always dropped.
    function automatic logic [15:0] word_align(input logic [15:0] addr);
        return addr & 16'hFFFE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_jump_cond_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch_unit_jump_cond_eval : jump condition code vs {V,N,Z,C} -> take     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module pc_fetch_unit_jump_cond_eval
    import pc_fetch_unit_pkg::*;
(
    input  logic [2:0] jmp_cond,
    input  logic [3:0] sr_flags,
    output logic       take
);

    logic w_v, w_n, w_z, w_c;

    assign {w_v, w_n, w_z, w_c} = sr_flags;

    always_comb begin
        take = 1'b0;
        case (jmp_cond)
            c_JCC_JNE: take = ~w_z;
            c_JCC_JEQ: take = w_z;
            c_JCC_JNC: take = ~w_c;
            c_JCC_JC:  take = w_c;
            c_JCC_JN:  take = w_n;
            c_JCC_JGE: take = ~(w_n ^ w_v);
            c_JCC_JL:  take = w_n ^ w_v;
            c_JCC_JMP: take = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch_unit : PC register, MPC resolution, MAB mux and ROM req/ack        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_VEC_ADDR = c_RESET_VEC_ADDR,
    parameter int unsigned WAIT_TIMEOUT   = 15
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  MPC,
    input  logic [2:0]  MAB_sel,
    input  logic [2:0]  jmp_cond,
    input  logic [9:0]  jmp_off,
    input  logic [3:0]  sr_flags,
    input  logic [15:0] reg_Din,
    input  logic [15:0] Sout,
    input  logic [15:0] CALC_out,
    input  logic [15:0] MDB_out,
    input  logic        rom_ack,
    output logic [15:0] reg_PC_out,
    output logic [15:0] MAB_in,
    output logic        rom_req,
    output logic        MAB_done,
    output logic        instr_valid,
    output logic        jump_taken,
    output logic        bus_err
);

    localparam logic [3:0] c_WAIT_LIMIT = 4'(WAIT_TIMEOUT);

    fetch_state_t r_state, w_state_next;
    logic [15:0]  r_pc, w_pc_next;
    logic [3:0]   r_wait_cnt, w_wait_cnt_next, w_wait_inc;
    logic         r_rom_req, r_mab_done, r_instr_valid, r_jump_taken, r_bus_err;
    logic         w_take, w_fetch_done, w_mab_is_pc, w_inc_ok, w_jump, w_timeout;
    logic [15:0]  w_mab, w_jmp_target;

    pc_fetch_unit_jump_cond_eval u_jump_cond_eval (
        .jmp_cond (jmp_cond),
        .sr_flags (sr_flags),
        .take     (w_take)
    );

    assign w_fetch_done = r_rom_req & rom_ack;
    assign w_jmp_target = r_pc + {{5{jmp_off[9]}}, jmp_off, 1'b0};
    assign w_wait_inc   = r_wait_cnt + 4'd1;
    // Unused MAB_sel codes fall back to the PC, so they also count as a PC fetch.
    assign w_mab_is_pc  = (MAB_sel != c_MAB_SEL_SOUT) && (MAB_sel != c_MAB_SEL_CALC) &&
                          (MAB_sel != c_MAB_SEL_MDB);
    assign w_inc_ok     = w_fetch_done & w_mab_is_pc;

    always_comb begin
        w_mab = r_pc;
        if (r_state == ST_VEC) begin
            w_mab = RESET_VEC_ADDR;
        end else begin
            case (MAB_sel)
                c_MAB_SEL_SOUT: w_mab = Sout;
                c_MAB_SEL_CALC: w_mab = CALC_out;
                c_MAB_SEL_MDB:  w_mab = MDB_out;
                default:        w_mab = r_pc;
            endcase
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_wait_cnt_next = '0;
        w_jump          = 1'b0;
        w_timeout       = 1'b0;

        if (r_rom_req && !rom_ack) begin
            if (w_wait_inc == c_WAIT_LIMIT) begin
                w_timeout = 1'b1;
            end else begin
                w_wait_cnt_next = w_wait_inc;
            end
        end

        case (r_state)
            ST_VEC: begin
                if (w_timeout) begin
                    w_state_next = ST_ERR;
                end else if (w_fetch_done) begin
                    w_pc_next    = word_align(MDB_out);
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A bus error outranks any PC update requested in the same cycle.
                if (w_timeout) begin
                    w_state_next = ST_ERR;
                end else begin
                    case (MPC)
                        c_MPC_JCC: begin
                            if (w_take) begin
                                w_jump    = 1'b1;
                                w_pc_next = w_jmp_target;
                            end else if (w_inc_ok) begin
                                w_pc_next = r_pc + 16'd2;
                            end
                        end
                        c_MPC_LOAD: begin
                            w_jump    = 1'b1;
                            w_pc_next = word_align(reg_Din);
                        end
                        c_MPC_INC: begin
                            if (w_inc_ok) begin
                                w_pc_next = r_pc + 16'd2;
                            end
                        end
                        default: ;
                    endcase
                    if (w_jump) begin
                        w_state_next    = ST_FLUSH;
                        w_wait_cnt_next = '0;
                    end
                end
            end
            ST_FLUSH: w_state_next = ST_RUN;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_VEC;
            r_pc          <= 16'h0000;
            r_wait_cnt    <= '0;
            r_rom_req     <= 1'b0;
            r_mab_done    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_jump_taken  <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_rom_req     <= (w_state_next == ST_VEC) || (w_state_next == ST_RUN);
            r_mab_done    <= w_fetch_done;
            // A word acked alongside a taken jump belongs to the abandoned stream.
            r_instr_valid <= w_fetch_done && (r_state == ST_RUN) && !w_jump &&
                             (w_mab == r_pc);
            r_jump_taken  <= w_jump;
            r_bus_err     <= r_bus_err | w_timeout;
        end
    end

    assign reg_PC_out  = r_pc;
    assign MAB_in      = w_mab;
    assign rom_req     = r_rom_req;
    assign MAB_done    = r_mab_done;
    assign instr_valid = r_instr_valid;
    assign jump_taken  = r_jump_taken;
    assign bus_err     = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_fetch_unit : directed self-checking bench with MAB_done scoreboard    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  MPC, MAB_sel, jmp_cond;
    logic [9:0]  jmp_off;
    logic [3:0]  sr_flags;
    logic [15:0] reg_Din, Sout, CALC_out, MDB_out;
    logic        rom_ack;
    logic [15:0] reg_PC_out, MAB_in;
    logic        rom_req, MAB_done, instr_valid, jump_taken, bus_err;

    int checks = 0;
    int errors = 0;
    logic sb_q[$];

    pc_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MPC         (MPC),
        .MAB_sel     (MAB_sel),
        .jmp_cond    (jmp_cond),
        .jmp_off     (jmp_off),
        .sr_flags    (sr_flags),
        .reg_Din     (reg_Din),
        .Sout        (Sout),
        .CALC_out    (CALC_out),
        .MDB_out     (MDB_out),
        .rom_ack     (rom_ack),
        .reg_PC_out  (reg_PC_out),
        .MAB_in      (MAB_in),
        .rom_req     (rom_req),
        .MAB_done    (MAB_done),
        .instr_valid (instr_valid),
        .jump_taken  (jump_taken),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive ack, check rom_req, push the expected instr_valid of an
    // accepted access, then pop it when MAB_done shows up a cycle later.
    task automatic cyc(input logic ack, input logic exp_req, input logic exp_iv);
        rom_ack = ack;
        chk("rom_req", rom_req, exp_req);
        if (ack && exp_req) sb_q.push_back(exp_iv);
        @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            chk("mab_done", MAB_done, 1'b1);
            chk("instr_valid", instr_valid, sb_q.pop_front());
        end else begin
            chk("mab_done_idle", MAB_done, 1'b0);
            chk("instr_valid_idle", instr_valid, 1'b0);
        end
        rom_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; MPC = 3'd0; MAB_sel = 3'd0; jmp_cond = 3'd0; jmp_off = 10'd0;
        sr_flags = 4'd0; reg_Din = 16'd0; Sout = 16'd0; CALC_out = 16'd0;
        MDB_out = 16'd0; rom_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rom_req", rom_req, 1'b0);
        chk("rst_pc", reg_PC_out, 16'h0000);
        chk("rst_mab_vec", MAB_in, 16'hFFFE);
        chk("rst_jump_taken", jump_taken, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);

        // Vector fetch with two wait states; MPC must be ignored in VEC.
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        MDB_out = 16'hC001; MPC = 3'd2; reg_Din = 16'h1111;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("vec_mab", MAB_in, 16'hFFFE);
        cyc(1'b1, 1'b1, 1'b0);
        chk("vec_pc", reg_PC_out, 16'hC000);
        chk("vec_jump_taken", jump_taken, 1'b0);

        // Sequential increments.
        MPC = 3'd1;
        for (int i = 0; i < 3; i++) begin
            chk("inc_mab", MAB_in, 16'hC000 + 16'(2 * i));
            cyc(1'b1, 1'b1, 1'b1);
            chk("inc_pc", reg_PC_out, 16'hC002 + 16'(2 * i));
        end

        // Load PC, then an ack during FLUSH must be ignored.
        MPC = 3'd2; reg_Din = 16'hC010;
        cyc(1'b0, 1'b1, 1'b0);
        chk("load_pc", reg_PC_out, 16'hC010);
        chk("load_jump_taken", jump_taken, 1'b1);
        MPC = 3'd0;
        cyc(1'b1, 1'b0, 1'b0);
        chk("flush_end_jt", jump_taken, 1'b0);

        // JEQ taken with simultaneous ack: jump wins, word discarded.
        MPC = 3'd3; jmp_cond = 3'd1; sr_flags = 4'b0010; jmp_off = 10'h3FE;
        cyc(1'b1, 1'b1, 1'b0);
        chk("jeq_pc", reg_PC_out, 16'hC00C);
        chk("jeq_jump_taken", jump_taken, 1'b1);
        MPC = 3'd0;
        cyc(1'b0, 1'b0, 1'b0);

        // Same jump, Z=0: falls back to an increment.
        MPC = 3'd2; reg_Din = 16'hC010;
        cyc(1'b0, 1'b1, 1'b0);
        MPC = 3'd0;
        cyc(1'b0, 1'b0, 1'b0);
        MPC = 3'd3; sr_flags = 4'b0000;
        cyc(1'b1, 1'b1, 1'b1);
        chk("jeq_nt_pc", reg_PC_out, 16'hC012);
        chk("jeq_nt_jt", jump_taken, 1'b0);

        // JN not taken without ack holds; JGE taken with N=V=1.
        jmp_cond = 3'd4;
        cyc(1'b0, 1'b1, 1'b0);
        chk("jn_nt_pc", reg_PC_out, 16'hC012);
        jmp_cond = 3'd5; sr_flags = 4'b1100; jmp_off = 10'h005;
        cyc(1'b0, 1'b1, 1'b0);
        chk("jge_pc", reg_PC_out, 16'hC01C);
        chk("jge_jt", jump_taken, 1'b1);
        MPC = 3'd0;
        cyc(1'b0, 1'b0, 1'b0);

        // Wrap-around on increment and on a negative JMP offset.
        MPC = 3'd2; reg_Din = 16'hFFFF;
        cyc(1'b0, 1'b1, 1'b0);
        chk("align_pc", reg_PC_out, 16'hFFFE);
        MPC = 3'd0;
        cyc(1'b0, 1'b0, 1'b0);
        MPC = 3'd1;
        cyc(1'b1, 1'b1, 1'b1);
        chk("wrap_inc_pc", reg_PC_out, 16'h0000);
        MPC = 3'd3; jmp_cond = 3'd7; jmp_off = 10'h3FE;
        cyc(1'b0, 1'b1, 1'b0);
        chk("wrap_jmp_pc", reg_PC_out, 16'hFFFC);
        MPC = 3'd0;
        cyc(1'b0, 1'b0, 1'b0);
        MPC = 3'd2; reg_Din = 16'h1235;
        cyc(1'b0, 1'b1, 1'b0);
        chk("load1235_pc", reg_PC_out, 16'h1234);
        chk("load1235_jt", jump_taken, 1'b1);
        MPC = 3'd0;
        cyc(1'b0, 1'b0, 1'b0);

        // Data access via Sout: no instr_valid, PC holds despite MPC=1.
        MPC = 3'd1; MAB_sel = 3'd1; Sout = 16'h0200;
        #1 chk("mab_sout", MAB_in, 16'h0200);
        cyc(1'b1, 1'b1, 1'b0);
        chk("sout_pc", reg_PC_out, 16'h1234);
        MPC = 3'd0; MAB_sel = 3'd2; CALC_out = 16'h0300;
        #1 chk("mab_calc", MAB_in, 16'h0300);
        MAB_sel = 3'd3; MDB_out = 16'h0400;
        #1 chk("mab_mdb", MAB_in, 16'h0400);
        MAB_sel = 3'd5;
        #1 chk("mab_default", MAB_in, 16'h1234);
        MAB_sel = 3'd0;

        // Timeout after 15 unacknowledged cycles.
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 1'b0);
        chk("pre_timeout_err", bus_err, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("timeout_err", bus_err, 1'b1);
        MPC = 3'd2; reg_Din = 16'h5555;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("err_pc_frozen", reg_PC_out, 16'h1234);
        chk("err_jt", jump_taken, 1'b0);
        chk("err_sticky", bus_err, 1'b1);
        MPC = 3'd0;

        // Reset clears the error; a second reset abandons the vector fetch.
        rst_n = 1'b0;
        #1;
        chk("rst2_bus_err", bus_err, 1'b0);
        chk("rst2_pc", reg_PC_out, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1 chk("rst_mid_req", rom_req, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        MDB_out = 16'h8001;
        chk("refetch_mab", MAB_in, 16'hFFFE);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("refetch_pc", reg_PC_out, 16'h8000);
        chk("refetch_err", bus_err, 1'b0);
        chk("sb_empty", 16'(sb_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and memory-address stage directly upstream of the instruction decoder.
- Owns the PC register and loads the reset vector out of reset.
- Resolves the decoder's MPC select (hold, increment, load, conditional jump).
- Muxes the MAB source from the decoder's MAB_sel.
- Runs a request/acknowledge handshake with ROM, so reg_PC_out, MAB_in and MAB_done are produced with proper wait-state tolerance.

Parameters:
RESET_VEC_ADDR, 16'hFFFE, address of reset vector word.
WAIT_TIMEOUT, 15, max cycles rom_req may stay unacknowledged before bus error (4-bit counter).

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
MPC  in  3  PC select from decoder: 0 hold, 1 increment, 2 load reg_Din, 3 conditional jump; 4-7 treated as hold
MAB_sel  in  3  MAB source: 0 PC, 1 Sout, 2 CALC_out, 3 MDB_out; 4-7 -> PC
jmp_cond  in  3  jump condition code (instruction bits 12:10)
jmp_off  in  10  signed word offset (instruction bits 9:0)
sr_flags  in  4  {V,N,Z,C} from status register
reg_Din  in  16  PC load value for MPC=2
Sout  in  16  register-file source output
CALC_out  in  16  indexed-address calculator result
MDB_out  in  16  ROM/memory data bus
rom_ack  in  1  memory access complete this cycle
reg_PC_out  out  16  current PC
MAB_in  out  16  memory address bus
rom_req  out  1  memory access request
MAB_done  out  1  one-cycle pulse: access completed, MDB_out valid
instr_valid  out  1  MDB_out holds an instruction word fetched at PC
jump_taken  out  1  one-cycle pulse on taken jump or PC load
bus_err  out  1  sticky timeout error

Behaviour:
Reset (async, rst_n low):
- state=VEC, PC=16'h0000.
- rom_req, MAB_done, instr_valid, jump_taken and bus_err are 0; wait_cnt=0.
- MAB_in=RESET_VEC_ADDR while in VEC.

States VEC, RUN, FLUSH, ERR:
- VEC:
  - rom_req=1 from the first clk after rst_n rises.
  - On rom_ack: PC<={MDB_out[15:1],1'b0}, MAB_done pulse, go RUN.
  - MPC is ignored.
- RUN:
  - rom_req=1 continuously.
  - MAB_in is a combinational mux per MAB_sel.
  - fetch_done = rom_req & rom_ack.
  - MAB_done registered from fetch_done (1-cycle latency).
  - instr_valid = MAB_done & (MAB address latched at ack == PC at ack).
- PC update at posedge, priority order:
  - MPC=3 and condition true: PC<=PC+{{5{jmp_off[9]}},jmp_off,1'b0}; jump_taken pulse; go FLUSH.
  - MPC=3 and condition false: treated as MPC=1.
  - MPC=2: PC<={reg_Din[15:1],1'b0}; jump_taken pulse; go FLUSH.
  - MPC=1: PC<=PC+2, only on a cycle with fetch_done and MAB_sel=PC; otherwise hold.
  - MPC=0 or 4-7: hold.
- Jump conditions (jmp_cond):
  - 0 JNE ~Z; 1 JEQ Z; 2 JNC ~C; 3 JC C.
  - 4 JN N; 5 JGE ~(N^V); 6 JL N^V; 7 JMP always.
- Arithmetic: 16-bit modulo. 16'hFFFE+2 = 16'h0000. Negative offsets wrap likewise.
- FLUSH:
  - Lasts exactly one cycle: rom_req=0, instr_valid=0. Any rom_ack here is ignored.
  - Then return to RUN.
- Simultaneous taken jump/load and rom_ack: the jump wins. The acked word is discarded: MAB_done still pulses, instr_valid=0.
- Timeout:
  - wait_cnt increments each cycle rom_req=1 & rom_ack=0; it clears on ack or leaving RUN/VEC.
  - Reaching WAIT_TIMEOUT: bus_err<=1, go ERR.
- ERR:
  - rom_req=0, PC frozen, all pulses 0.
  - Exit only via reset.
- Reset mid-access: abandons the access immediately, and the vector fetch restarts.

Decomposition:
- Shared header msp430_ops.vh holds:
  - MPC_* and MAB_SEL_* encodings.
  - JCC_* condition codes.
  - Fetch state encodings.
  - Default RESET_VEC_ADDR.
- One natural sub-module: jump_cond_eval. Combinational, jmp_cond + sr_flags -> take. Reusable by the decoder for JMP FS handling.

Test Plan:
- Reset, ROM returns 16'hC001 at 16'hFFFE after 2 wait cycles -> rom_req high 3 cycles, PC=16'hC000, MAB_done one pulse, state RUN.
- PC=16'hC000, MPC=1, ack every cycle for 3 cycles -> PC C002, C004, C006; instr_valid high each following cycle.
- PC=16'hC010, MPC=3, jmp_cond=1, Z=1, jmp_off=10'h3FE (-2) -> PC=16'hC00C, jump_taken pulse, one FLUSH cycle with rom_req=0. Same stimulus with Z=0 -> PC=16'hC012, no flush.
- PC=16'hFFFE, MPC=1 with ack -> PC=16'h0000. MPC=2, reg_Din=16'h1235 -> PC=16'h1234, jump_taken.
- MAB_sel=1, Sout=16'h0200, ack -> MAB_in=16'h0200, MAB_done pulse, instr_valid=0, PC unchanged.
- rom_ack held low 15 cycles in RUN -> bus_err=1, rom_req=0, PC frozen. rst_n pulse -> bus_err=0, VEC refetch.
